// File: rtl/funct_generator_shadow_regbank.sv
// -----------------------------------------------------------------------------
// funct_generator_shadow_regbank
// Double-buffered register bank for the waveform generator. Software writes
// land in shadow registers. A commit request copies every shadow value into
// the active registers in one edge. The copy waits for the generator sync
// pulse, or happens at once when IMMEDIATE = 1. Readback is registered and
// can return either the shadow copy or the active copy.
//
// Ports
//   i_clk            clock (all state on posedge)
//   i_rst            synchronous active-high reset
//   i_clrh           synchronous clear (same effect as reset, lower priority)
//   i_wr_en          shadow write strobe
//   i_wr_addr        shadow write address (out-of-range writes are ignored)
//   i_wr_data        shadow write data
//   i_rd_en          read request; data appears one cycle later
//   i_rd_addr        read address (out-of-range reads return 0)
//   i_rd_active      1 = read active copy, 0 = read shadow copy
//   o_rd_data        registered read data (holds when no read is requested)
//   o_rd_valid       one-cycle pulse per read request
//   i_commit_req     request a shadow->active transfer
//   i_sync           generator frame-boundary pulse
//   o_commit_pending commit armed and waiting for sync
//   o_commit_ack     one-cycle pulse after a transfer
//   o_dirty          per-register flag: shadow written since the last transfer
//   o_active_q       all active registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module funct_generator_shadow_regbank #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    NUM_REGS    = 4,
    parameter int                    ADDR_WIDTH  = $clog2(NUM_REGS),
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}},
    parameter bit                    IMMEDIATE   = 1'b0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_clrh,
    input  logic                           i_wr_en,
    input  logic [ADDR_WIDTH-1:0]          i_wr_addr,
    input  logic [DATA_WIDTH-1:0]          i_wr_data,
    input  logic                           i_rd_en,
    input  logic [ADDR_WIDTH-1:0]          i_rd_addr,
    input  logic                           i_rd_active,
    output logic [DATA_WIDTH-1:0]          o_rd_data,
    output logic                           o_rd_valid,
    input  logic                           i_commit_req,
    input  logic                           i_sync,
    output logic                           o_commit_pending,
    output logic                           o_commit_ack,
    output logic [NUM_REGS-1:0]            o_dirty,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_active_q
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_req_eff;
    logic                  w_transfer;
    logic                  w_clear;
    logic [NUM_REGS-1:0]   w_wr_hit;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic [DATA_WIDTH-1:0] r_shadow [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_active [NUM_REGS];
    logic [NUM_REGS-1:0]   r_dirty;
    logic                  r_commit_ack;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Reset and clear are identical in effect, so one combined clear term suffices.
    assign w_clear = i_rst | i_clrh;

    // Commit FSM next-state: an armed request behaves like a held request.
    always_comb begin
        w_next_state = r_state;
        w_req_eff    = i_commit_req | (r_state == ST_ARMED);
        w_transfer   = w_req_eff & (i_sync | IMMEDIATE);
        case (r_state)
            ST_IDLE: begin
                if (w_transfer) begin
                    w_next_state = ST_IDLE;
                end else if (i_commit_req) begin
                    w_next_state = ST_ARMED;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (w_transfer) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_ARMED;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Write decode and read mux as AND-OR over the in-range registers only,
    // so an out-of-range address selects nothing and reads back as zero.
    always_comb begin
        w_wr_hit  = {NUM_REGS{1'b0}};
        w_rd_word = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_hit[i] = i_wr_en & (i_wr_addr == ADDR_WIDTH'(i));
            w_rd_word   = w_rd_word
                        | ({DATA_WIDTH{i_rd_addr == ADDR_WIDTH'(i)}}
                           & (i_rd_active ? r_active[i] : r_shadow[i]));
        end
    end

    // Control state: FSM, dirty flags, ack pulse and registered readback.
    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            r_state      <= ST_IDLE;
            r_dirty      <= {NUM_REGS{1'b0}};
            r_commit_ack <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state      <= w_next_state;
            // A write in the transfer cycle keeps only its own register dirty.
            r_dirty      <= w_wr_hit | (w_transfer ? {NUM_REGS{1'b0}} : r_dirty);
            r_commit_ack <= w_transfer;
            r_rd_valid   <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= w_rd_word;
            end else begin
                r_rd_data <= r_rd_data;
            end
        end
    end

    // Register bank: active copies the pre-edge shadow, so a same-cycle write
    // lands only in the shadow.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_clear) begin
                r_shadow[i] <= RESET_VALUE;
                r_active[i] <= RESET_VALUE;
            end else begin
                if (w_wr_hit[i]) begin
                    r_shadow[i] <= i_wr_data;
                end else begin
                    r_shadow[i] <= r_shadow[i];
                end
                if (w_transfer) begin
                    r_active[i] <= r_shadow[i];
                end else begin
                    r_active[i] <= r_active[i];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_active_q
            assign o_active_q[g*DATA_WIDTH +: DATA_WIDTH] = r_active[g];
        end
    endgenerate

    assign o_commit_pending = (r_state == ST_ARMED);
    assign o_commit_ack     = r_commit_ack;
    assign o_dirty          = r_dirty;
    assign o_rd_valid       = r_rd_valid;
    assign o_rd_data        = r_rd_data;

endmodule

// File: tb/tb_funct_generator_shadow_regbank.sv
// -----------------------------------------------------------------------------
// Bench for funct_generator_shadow_regbank. Three configurations run in
// lockstep on one shared stimulus bus:
//   u0: 8-bit x 4 regs, reset 8'h5A, deferred commit
//   u1: 8-bit x 3 regs, reset 8'h5A, deferred commit (address 3 out of range)
//   u2: 16-bit x 8 regs, reset 16'h1234, immediate commit
// A per-instance reference model tracks shadow/active contents and commit
// state from the behavioural rules; every cycle all outputs are compared.
// -----------------------------------------------------------------------------
module tb_funct_generator_shadow_regbank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        t_rst, t_clrh, t_wr_en, t_rd_en, t_rd_active, t_commit_req, t_sync;
    logic [2:0]  t_wr_addr, t_rd_addr;
    logic [15:0] t_wr_data;

    logic [31:0]  q0;
    logic [23:0]  q1;
    logic [127:0] q2;
    logic [3:0]   d0;
    logic [2:0]   d1;
    logic [7:0]   d2;
    logic [7:0]   r0, r1;
    logic [15:0]  r2;
    logic         v0, v1, v2, p0, p1, p2, a0, a1, a2;

    funct_generator_shadow_regbank #(
        .DATA_WIDTH(8), .NUM_REGS(4), .RESET_VALUE(8'h5A), .IMMEDIATE(1'b0)
    ) u0 (
        .i_clk(clk), .i_rst(t_rst), .i_clrh(t_clrh),
        .i_wr_en(t_wr_en), .i_wr_addr(t_wr_addr[1:0]), .i_wr_data(t_wr_data[7:0]),
        .i_rd_en(t_rd_en), .i_rd_addr(t_rd_addr[1:0]), .i_rd_active(t_rd_active),
        .o_rd_data(r0), .o_rd_valid(v0),
        .i_commit_req(t_commit_req), .i_sync(t_sync),
        .o_commit_pending(p0), .o_commit_ack(a0), .o_dirty(d0), .o_active_q(q0)
    );

    funct_generator_shadow_regbank #(
        .DATA_WIDTH(8), .NUM_REGS(3), .RESET_VALUE(8'h5A), .IMMEDIATE(1'b0)
    ) u1 (
        .i_clk(clk), .i_rst(t_rst), .i_clrh(t_clrh),
        .i_wr_en(t_wr_en), .i_wr_addr(t_wr_addr[1:0]), .i_wr_data(t_wr_data[7:0]),
        .i_rd_en(t_rd_en), .i_rd_addr(t_rd_addr[1:0]), .i_rd_active(t_rd_active),
        .o_rd_data(r1), .o_rd_valid(v1),
        .i_commit_req(t_commit_req), .i_sync(t_sync),
        .o_commit_pending(p1), .o_commit_ack(a1), .o_dirty(d1), .o_active_q(q1)
    );

    funct_generator_shadow_regbank #(
        .DATA_WIDTH(16), .NUM_REGS(8), .RESET_VALUE(16'h1234), .IMMEDIATE(1'b1)
    ) u2 (
        .i_clk(clk), .i_rst(t_rst), .i_clrh(t_clrh),
        .i_wr_en(t_wr_en), .i_wr_addr(t_wr_addr), .i_wr_data(t_wr_data),
        .i_rd_en(t_rd_en), .i_rd_addr(t_rd_addr), .i_rd_active(t_rd_active),
        .o_rd_data(r2), .o_rd_valid(v2),
        .i_commit_req(t_commit_req), .i_sync(t_sync),
        .o_commit_pending(p2), .o_commit_ack(a2), .o_dirty(d2), .o_active_q(q2)
    );

    // Observed outputs gathered per instance, zero-extended to common widths.
    logic [127:0] oq [3];
    logic [7:0]   od [3];
    logic [15:0]  ord [3];
    logic         ov [3], op [3], oa [3];
    assign oq[0] = {96'd0, q0};
    assign oq[1] = {104'd0, q1};
    assign oq[2] = q2;
    assign od[0] = {4'd0, d0};
    assign od[1] = {5'd0, d1};
    assign od[2] = d2;
    assign ord[0] = {8'd0, r0};
    assign ord[1] = {8'd0, r1};
    assign ord[2] = r2;
    assign ov[0] = v0;
    assign ov[1] = v1;
    assign ov[2] = v2;
    assign op[0] = p0;
    assign op[1] = p1;
    assign op[2] = p2;
    assign oa[0] = a0;
    assign oa[1] = a1;
    assign oa[2] = a2;

    // Instance configurations.
    int          cfg_dw  [3] = '{8, 8, 16};
    int          cfg_nr  [3] = '{4, 3, 8};
    int          cfg_aw  [3] = '{2, 2, 3};
    bit          cfg_imm [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] cfg_rv  [3] = '{16'h005A, 16'h005A, 16'h1234};

    // Reference model state.
    logic [15:0] m_sh    [3][8];
    logic [15:0] m_ac    [3][8];
    logic [7:0]  m_dirty [3];
    bit          m_armed [3];
    bit          m_ack   [3];
    bit          m_rdv   [3];
    logic [15:0] m_rdd   [3];

    int checks   = 0;
    int failures = 0;
    int ack_cnt;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the behavioural rules, applied to all three configs.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int          amask;
            int          wa;
            int          ra;
            bit          fire;
            logic [15:0] dmask;
            amask = (1 << cfg_aw[k]) - 1;
            wa    = int'(t_wr_addr) & amask;
            ra    = int'(t_rd_addr) & amask;
            dmask = (cfg_dw[k] == 16) ? 16'hFFFF : 16'h00FF;
            if (t_rst || t_clrh) begin
                for (int i = 0; i < 8; i++) begin
                    m_sh[k][i] = cfg_rv[k];
                    m_ac[k][i] = cfg_rv[k];
                end
                m_dirty[k] = 8'd0;
                m_armed[k] = 1'b0;
                m_ack[k]   = 1'b0;
                m_rdv[k]   = 1'b0;
                m_rdd[k]   = 16'd0;
            end else begin
                // Reads see the contents from before this edge.
                if (t_rd_en) begin
                    if (ra < cfg_nr[k]) begin
                        m_rdd[k] = t_rd_active ? m_ac[k][ra] : m_sh[k][ra];
                    end else begin
                        m_rdd[k] = 16'd0;
                    end
                end
                m_rdv[k] = t_rd_en;
                fire = (t_commit_req || m_armed[k]) && (t_sync || cfg_imm[k]);
                if (fire) begin
                    for (int i = 0; i < 8; i++) m_ac[k][i] = m_sh[k][i];
                    m_dirty[k] = 8'd0;
                    m_armed[k] = 1'b0;
                end else begin
                    m_armed[k] = m_armed[k] | t_commit_req;
                end
                m_ack[k] = fire;
                if (t_wr_en && (wa < cfg_nr[k])) begin
                    m_sh[k][wa]    = t_wr_data & dmask;
                    m_dirty[k][wa] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [127:0] pack_q(input int k);
        logic [127:0] v;
        v = 128'd0;
        for (int i = 0; i < cfg_nr[k]; i++) begin
            v = v | (128'(m_ac[k][i]) << (i * cfg_dw[k]));
        end
        return v;
    endfunction

    // Advance one cycle and compare every output of every instance.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("u%0d.active_q", k), oq[k], pack_q(k));
            check_eq($sformatf("u%0d.dirty", k), 128'(od[k]), 128'(m_dirty[k]));
            check_eq($sformatf("u%0d.commit_pending", k), 128'(op[k]), 128'(m_armed[k]));
            check_eq($sformatf("u%0d.commit_ack", k), 128'(oa[k]), 128'(m_ack[k]));
            check_eq($sformatf("u%0d.rd_valid", k), 128'(ov[k]), 128'(m_rdv[k]));
            check_eq($sformatf("u%0d.rd_data", k), 128'(ord[k]), 128'(m_rdd[k]));
        end
    endtask

    task automatic idle();
        t_rst        = 1'b0;
        t_clrh       = 1'b0;
        t_wr_en      = 1'b0;
        t_wr_addr    = 3'd0;
        t_wr_data    = 16'd0;
        t_rd_en      = 1'b0;
        t_rd_addr    = 3'd0;
        t_rd_active  = 1'b0;
        t_commit_req = 1'b0;
        t_sync       = 1'b0;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        t_wr_en   = 1'b1;
        t_wr_addr = addr;
        t_wr_data = data;
    endtask

    initial begin
        // Reset
        idle();
        t_rst = 1'b1;
        tick();
        idle();
        check_eq("rst.u0_active_q", oq[0], {96'd0, 32'h5A5A5A5A});
        check_eq("rst.u0_dirty", 128'(od[0]), 128'd0);
        check_eq("rst.u0_pending", 128'(op[0]), 128'd0);
        check_eq("rst.u2_active_q", oq[2], {8{16'h1234}});

        // Clear while armed cancels the commit without an ack
        wr(3'd0, 16'h0077); tick(); idle();
        t_commit_req = 1'b1; tick(); idle();
        check_eq("clr.u0_pending_armed", 128'(op[0]), 128'd1);
        t_clrh = 1'b1; tick(); idle();
        check_eq("clr.u0_active_q", oq[0], {96'd0, 32'h5A5A5A5A});
        check_eq("clr.u0_pending", 128'(op[0]), 128'd0);
        check_eq("clr.u0_ack", 128'(oa[0]), 128'd0);
        t_sync = 1'b1; tick(); idle();
        check_eq("clr.u0_ack_after_sync", 128'(oa[0]), 128'd0);

        // Deferred commit waits for sync
        wr(3'd2, 16'h00C3); tick(); idle();
        t_commit_req = 1'b1; tick(); idle();
        check_eq("defer.u0_pending", 128'(op[0]), 128'd1);
        check_eq("defer.u0_active_q_held", oq[0], {96'd0, 32'h5A5A5A5A});
        repeat (4) tick();
        t_sync = 1'b1; tick(); idle();
        check_eq("defer.u0_active_q", oq[0], {96'd0, 32'h5AC35A5A});
        check_eq("defer.u0_ack", 128'(oa[0]), 128'd1);
        check_eq("defer.u0_dirty", 128'(od[0]), 128'd0);
        check_eq("defer.u0_pending_clr", 128'(op[0]), 128'd0);
        tick();
        check_eq("defer.u0_ack_one_cycle", 128'(oa[0]), 128'd0);

        // Write in the same cycle as the transfer
        wr(3'd1, 16'h0011); tick(); idle();
        t_commit_req = 1'b1; tick(); idle();
        wr(3'd1, 16'h0022); t_sync = 1'b1; tick(); idle();
        check_eq("same.u0_active_q", oq[0], {96'd0, 32'h5AC3115A});
        check_eq("same.u0_dirty", 128'(od[0]), 128'd2);
        t_rd_en = 1'b1; t_rd_addr = 3'd1; tick(); idle();
        check_eq("same.u0_shadow_rd", 128'(ord[0]), 128'h22);

        // Readback of shadow, active and an out-of-range address
        wr(3'd3, 16'h00A5); tick(); idle();
        t_rd_en = 1'b1; t_rd_addr = 3'd3; tick(); idle();
        check_eq("rd.u0_shadow", 128'(ord[0]), 128'hA5);
        check_eq("rd.u0_valid", 128'(ov[0]), 128'd1);
        check_eq("rd.u1_oob", 128'(ord[1]), 128'd0);
        check_eq("rd.u1_oob_valid", 128'(ov[1]), 128'd1);
        t_rd_en = 1'b1; t_rd_addr = 3'd3; t_rd_active = 1'b1; tick(); idle();
        check_eq("rd.u0_active", 128'(ord[0]), 128'h5A);
        tick();
        check_eq("rd.u0_valid_drop", 128'(ov[0]), 128'd0);
        check_eq("rd.u0_hold", 128'(ord[0]), 128'h5A);

        // Request coincident with sync, then repeated requests
        t_commit_req = 1'b1; t_sync = 1'b1; tick(); idle();
        check_eq("coin.u0_ack", 128'(oa[0]), 128'd1);
        check_eq("coin.u0_pending", 128'(op[0]), 128'd0);
        ack_cnt = 0;
        for (int n = 0; n < 3; n++) begin
            t_commit_req = 1'b1; tick(); idle();
            ack_cnt += int'(oa[0]);
        end
        check_eq("rep.u0_pending", 128'(op[0]), 128'd1);
        t_sync = 1'b1; tick(); idle();
        ack_cnt += int'(oa[0]);
        repeat (2) begin
            tick();
            ack_cnt += int'(oa[0]);
        end
        check_eq("rep.u0_ack_count", 128'(ack_cnt), 128'd1);

        // Immediate mode commits without sync
        wr(3'd7, 16'hBEEF); tick(); idle();
        t_commit_req = 1'b1; tick(); idle();
        check_eq("imm.u2_reg7", 128'(q2[127:112]), 128'hBEEF);
        check_eq("imm.u2_ack", 128'(oa[2]), 128'd1);
        check_eq("imm.u2_pending", 128'(op[2]), 128'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            t_rst        = ($urandom_range(0, 63) == 0);
            t_clrh       = ($urandom_range(0, 31) == 0);
            t_wr_en      = 1'($urandom_range(0, 1));
            t_wr_addr    = 3'($urandom_range(0, 7));
            t_wr_data    = 16'($urandom);
            t_rd_en      = 1'($urandom_range(0, 1));
            t_rd_addr    = 3'($urandom_range(0, 7));
            t_rd_active  = 1'($urandom_range(0, 1));
            t_commit_req = ($urandom_range(0, 3) == 0);
            t_sync       = ($urandom_range(0, 3) == 0);
            tick();
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
